vr_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one valid_ready sink among `NUM_SRC` valid_ready sources, such as several `source` instances feeding a single sink. It grants one source at a time, captures its word into a one-entry output register, and presents that word on the master bus until the sink completes the handshake. An optional burst limit lets a winner keep the bus for several consecutive words. A per-source enable mask lets software remove requesters.

---
 rtl/vr_arb_pkg.sv | 14 +
 rtl/valid_ready_if.sv | 11 +
 rtl/rr_pick.sv | 36 +++
 rtl/vr_rr_arbiter.sv | 91 +++++++++
 tb/tb_vr_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vr_arb_pkg.sv
// rtl/vr_arb_pkg.sv - shared types and helpers for the valid_ready round-robin arbiter
package vr_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Explicit wrap so non-power-of-two source counts rotate correctly.
    function automatic int unsigned ptr_next(input int unsigned p, input int unsigned n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/valid_ready_if.sv
// rtl/valid_ready_if.sv - valid_ready handshake bus with Master/Slave views
interface valid_ready #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport Master (output valid, output data, input ready);
    modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker, search upward from ptr with wrap
module rr_pick #(
    parameter  int NUM_SRC = 4,
    localparam int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_SRC)) begin
                sum = sum - (IW+1)'(NUM_SRC);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/vr_rr_arbiter.sv
// rtl/vr_rr_arbiter.sv - round-robin arbiter sharing one valid_ready sink among NUM_SRC sources
module vr_rr_arbiter
    import vr_arb_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST      = 1,
    localparam int IW         = $clog2(NUM_SRC),
    localparam int BW         = $clog2(BURST) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_en,
    valid_ready.Slave          vr_in [NUM_SRC],
    valid_ready.Master         vr_out,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    arb_state_t            state;
    logic [IW-1:0]         ptr;
    logic [BW-1:0]         burst_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC-1:0]    gnt;
    logic [IW-1:0]         win_idx;
    logic [DATA_WIDTH-1:0] in_data [NUM_SRC];

    // Readies depend only on registered state and the requests, never on the sink.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign req[i]         = vr_in[i].valid & src_en[i];
        assign in_data[i]     = vr_in[i].data;
        assign vr_in[i].ready = (state == ARB_IDLE) & gnt[i];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    assign vr_out.valid = out_valid;
    assign vr_out.data  = out_data;
    assign busy         = out_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        out_data  <= in_data[win_idx];
                        grant_id  <= win_idx;
                        out_valid <= 1'b1;
                        state     <= ARB_HOLD;
                        // A held pointer that loses to another source ends the burst.
                        if (win_idx != grant_id) begin
                            burst_cnt <= '0;
                        end
                    end
                end
                ARB_HOLD: begin
                    if (vr_out.ready) begin
                        out_valid <= 1'b0;
                        state     <= ARB_IDLE;
                        if (32'(burst_cnt) + 32'd1 < 32'(BURST)) begin
                            burst_cnt <= burst_cnt + 1'b1;
                            ptr       <= grant_id;
                        end else begin
                            burst_cnt <= '0;
                            ptr       <= IW'(ptr_next(32'(grant_id), NUM_SRC));
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// tb/tb_vr_rr_arbiter.sv - scoreboard bench for vr_rr_arbiter, BURST=1 and BURST=3 instances
module tb_vr_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en  [2];
    logic [3:0] sv  [2];
    logic [7:0] sd  [2][4];
    logic       sr  [2];
    logic [3:0] rdy [2];
    logic [3:0] rdy0, rdy1;
    logic       ov  [2];
    logic [7:0] od  [2];
    logic [1:0] gid [2];
    logic       bsy [2];
    bit         adv [2][4];
    bit         inc_en;

    logic [9:0] q0[$], q1[$];
    int         glog0[$], glog1[$];
    int         hs [2][4];
    int         n_chk  = 0;
    int         n_pass = 0;

    valid_ready #(.DATA_WIDTH(8)) in0 [4] ();
    valid_ready #(.DATA_WIDTH(8)) in1 [4] ();
    valid_ready #(.DATA_WIDTH(8)) out0 ();
    valid_ready #(.DATA_WIDTH(8)) out1 ();

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign in0[i].valid = sv[0][i];
        assign in0[i].data  = sd[0][i];
        assign in1[i].valid = sv[1][i];
        assign in1[i].data  = sd[1][i];
        assign rdy0[i]      = in0[i].ready;
        assign rdy1[i]      = in1[i].ready;
    end
    assign rdy[0]     = rdy0;
    assign rdy[1]     = rdy1;
    assign out0.ready = sr[0];
    assign out1.ready = sr[1];
    assign ov[0] = out0.valid;
    assign od[0] = out0.data;
    assign ov[1] = out1.valid;
    assign od[1] = out1.data;

    vr_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .BURST(1)) u_rr (
        .clk      (clk),
        .reset    (reset),
        .src_en   (en[0]),
        .vr_in    (in0),
        .vr_out   (out0),
        .grant_id (gid[0]),
        .busy     (bsy[0])
    );

    vr_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH(8), .BURST(3)) u_bu (
        .clk      (clk),
        .reset    (reset),
        .src_en   (en[1]),
        .vr_in    (in1),
        .vr_out   (out1),
        .grant_id (gid[1]),
        .busy     (bsy[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_sb();
        q0.delete();
        q1.delete();
        glog0.delete();
        glog1.delete();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                hs[d][i]  = 0;
                adv[d][i] = 1'b0;
            end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        inc_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            sv[d] = 4'h0;
            en[d] = 4'hF;
            sr[d] = 1'b0;
            for (int i = 0; i < 4; i++) sd[d][i] = 8'(d * 128 + i * 16);
        end
        #1;
        clear_sb();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Negedge: log accepted input words and score completed output words; then advance sources.
    task automatic step();
        logic [9:0] e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (|rdy[d]) check("rdy_onehot", 32'($countones(rdy[d])), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (rdy[d][i]) begin
                    check("rdy_req", {31'd0, sv[d][i] & en[d][i]}, 32'd1);
                    if (d == 0) begin q0.push_back({2'(i), sd[d][i]}); glog0.push_back(i); end
                    else        begin q1.push_back({2'(i), sd[d][i]}); glog1.push_back(i); end
                    adv[d][i] = inc_en;
                end
            end
            if (ov[d] && sr[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    check("sb_unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check("sb_id", 32'(gid[d]), 32'(e[9:8]));
                    check("sb_data", 32'(od[d]), 32'(e[7:0]));
                    hs[d][gid[d]]++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (adv[d][i]) begin
                    sd[d][i]  = sd[d][i] + 8'd1;
                    adv[d][i] = 1'b0;
                end
    endtask

    initial begin
        int k;
        int bad;
        int exp_burst [7] = '{1, 1, 1, 3, 3, 3, 1};
        int exp_rr [5]    = '{0, 1, 2, 3, 0};

        do_reset();
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 32'(ov[d]), 32'd0);
            check("rst_data", 32'(od[d]), 32'd0);
            check("rst_gid", 32'(gid[d]), 32'd0);
            check("rst_busy", 32'(bsy[d]), 32'd0);
            check("rst_ready", 32'(rdy[d]), 32'd0);
        end

        // Single source 2, sink always ready: one word every two cycles.
        inc_en   = 1'b0;
        sd[0][2] = 8'h11;
        sv[0][2] = 1'b1;
        sr[0]    = 1'b1;
        #1;
        check("single_rdy_c1", 32'(rdy[0]), 32'h4);
        step();
        check("single_valid_c2", 32'(ov[0]), 32'd1);
        check("single_data_c2", 32'(od[0]), 32'h11);
        check("single_gid_c2", 32'(gid[0]), 32'd2);
        check("single_rdy_hold", 32'(rdy[0]), 32'h0);
        step();
        check("single_valid_c3", 32'(ov[0]), 32'd0);
        check("single_rdy_c3", 32'(rdy[0]), 32'h4);
        step();
        check("single_valid_c4", 32'(ov[0]), 32'd1);
        check("single_data_c4", 32'(od[0]), 32'h11);
        repeat (4) step();

        // Fairness: all four requesting, 400 handshakes.
        do_reset();
        sv[0] = 4'hF;
        sr[0] = 1'b1;
        for (k = 0; k < 1000 && (hs[0][0] + hs[0][1] + hs[0][2] + hs[0][3]) < 400; k++) step();
        check("fair_timeout", 32'(k < 1000), 32'd1);
        for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), 32'(glog0[i]), 32'(exp_rr[i]));
        for (int i = 0; i < 4; i++) check($sformatf("fair_share%0d", i), 32'(hs[0][i]), 32'd100);

        // Burst of 3 between sources 1 and 3.
        do_reset();
        sv[1] = 4'b1010;
        sr[1] = 1'b1;
        for (k = 0; k < 100 && glog1.size() < 7; k++) step();
        check("burst_timeout", 32'(glog1.size() >= 7), 32'd1);
        for (int i = 0; i < 7 && i < glog1.size(); i++)
            check($sformatf("burst_order%0d", i), 32'(glog1[i]), 32'(exp_burst[i]));

        // Source 1 drops after its second word mid-burst.
        do_reset();
        sv[1] = 4'b1010;
        sr[1] = 1'b1;
        for (k = 0; k < 50 && glog1.size() < 2; k++) step();
        sv[1][1] = 1'b0;
        for (k = 0; k < 50 && glog1.size() < 3; k++) step();
        check("drop_next3", 32'(glog1.size() >= 3 ? glog1[2] : -1), 32'd3);
        check("drop_cnt_clr", 32'(u_bu.burst_cnt), 32'd0);
        for (k = 0; k < 50 && glog1.size() < 5; k++) step();
        check("drop_then3", 32'(glog1.size() >= 5 ? glog1[4] : -1), 32'd3);
        sv[1] = 4'h0;
        repeat (3) step();

        // Sink stall with 0x5A held for 10 cycles.
        do_reset();
        inc_en   = 1'b0;
        sd[0][0] = 8'h5A;
        sv[0][0] = 1'b1;
        step();
        sv[0][0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", 32'(ov[0]), 32'd1);
            check("stall_data", 32'(od[0]), 32'h5A);
            check("stall_gid", 32'(gid[0]), 32'd0);
            check("stall_rdy", 32'(rdy[0]), 32'h0);
            step();
        end
        sr[0] = 1'b1;
        step();
        check("stall_release", 32'(ov[0]), 32'd0);
        check("stall_sb_empty", 32'(q0.size()), 32'd0);

        // Masking: only sources 1 and 3 may win.
        do_reset();
        en[0] = 4'b1010;
        sv[0] = 4'hF;
        sr[0] = 1'b1;
        repeat (20) step();
        bad = 0;
        foreach (glog0[j]) if (glog0[j] != 1 && glog0[j] != 3) bad++;
        check("mask_bad", 32'(bad), 32'd0);
        check("mask_count", 32'(glog0.size()), 32'd10);
        for (k = 0; k < 10 && !(ov[0] && gid[0] == 2'd1); k++) step();
        sr[0] = 1'b0;
        check("mask_hold1", 32'(ov[0] && gid[0] == 2'd1), 32'd1);
        en[0][1] = 1'b0;
        repeat (3) step();
        check("mask_held_valid", 32'(ov[0]), 32'd1);
        check("mask_held_gid", 32'(gid[0]), 32'd1);
        sr[0] = 1'b1;
        step();
        check("mask_held_sb", 32'(hs[0][1]), 32'd6);
        sv[0] = 4'h0;
        repeat (3) step();

        // Reset while a word is held; pointer had moved to 3 beforehand.
        do_reset();
        sv[0][2] = 1'b1;
        sr[0]    = 1'b1;
        repeat (2) step();
        sr[0] = 1'b0;
        step();
        check("rh_pending", 32'(ov[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("rh_valid_drop", 32'(ov[0]), 32'd0);
        check("rh_busy_drop", 32'(bsy[0]), 32'd0);
        clear_sb();
        @(posedge clk);
        #1;
        reset = 1'b1;
        sv[0] = 4'hF;
        sr[0] = 1'b1;
        #1;
        check("rh_first_rdy", 32'(rdy[0]), 32'h1);
        step();
        check("rh_first_gid", 32'(gid[0]), 32'd0);
        sv[0] = 4'h0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
